// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    // Multi-cycle ops are exactly the encodings 0..3.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// Request/result bundle between the E-stage pipeline and the md_unit.
interface md_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output Start, Op, A, B, input Busy, HI, LO);
    modport slave  (input Start, Op, A, B, output Busy, HI, LO);
endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath. Produces {hi, lo} for the given op
// and flags division by zero so the caller can leave HI/LO untouched.
module md_calc
    import md_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [63:0] res,
    output logic        div0
);

    logic        is_signed;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q;
    logic [31:0] r;

    // Divide on magnitudes then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000.
    always_comb begin
        is_signed = (op == MD_DIV);
        div0      = is_div_op(op) && (b == 32'd0);
        dvd       = (is_signed && a[31]) ? (~a + 32'd1) : a;
        dvs       = (is_signed && b[31]) ? (~b + 32'd1) : b;
        // Result is discarded on div0; a nonzero divisor keeps the divider X-free.
        if (dvs == 32'd0) begin
            dvs = 32'd1;
        end
        q_mag = dvd / dvs;
        r_mag = dvd % dvs;
        q     = (is_signed && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
        r     = (is_signed && a[31]) ? (~r_mag + 32'd1) : r_mag;

        res = '0;
        case (op)
            MD_MULT:          res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            MD_MULTU:         res = {32'd0, a} * {32'd0, b};
            MD_DIV, MD_DIVU:  res = {r, q};
            default:          res = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit. Owns HI/LO; multi-cycle ops compute their
// result at Start, hold it pending, and commit after a fixed Busy window.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic Clk,
    input  logic Clr,
    md_if.slave  bus
);

    md_state_e   state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_div0_q, pend_div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] calc_res;
    logic        calc_div0;

    md_calc u_calc (
        .a    (bus.A),
        .b    (bus.B),
        .op   (bus.Op),
        .res  (calc_res),
        .div0 (calc_div0)
    );

    // State register; synchronous active-low reset discards any in-flight op.
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_div0_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_div0_q <= pend_div0_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    // Next-state: accept requests only in IDLE; count down and commit in RUN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_div0_d = pend_div0_q;
        hi_d        = hi_q;
        lo_d        = lo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    if (is_md_op(bus.Op)) begin
                        pend_d      = calc_res;
                        pend_div0_d = calc_div0;
                        cnt_d       = is_div_op(bus.Op) ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                        state_d     = RUN;
                    end else if (bus.Op == MD_MTHI) begin
                        hi_d = bus.A;
                    end else if (bus.Op == MD_MTLO) begin
                        lo_d = bus.A;
                    end
                end
            end
            RUN: begin
                // Start is ignored here; the hazard unit must not issue it.
                cnt_d = cnt_q - 32'd1;
                if (cnt_q <= 32'd1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!pend_div0_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Busy = (state_q == RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases with literal expectations plus random
// traffic, all checked every cycle against a cycle-count/arithmetic model.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic Clk = 1'b0;
    logic Clr = 1'b0;

    md_if bus ();

    md_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    longint      cyc     = 0;
    longint      done_at = -1;    // edge number at which the pending op commits
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;
    logic [31:0] p_hi, p_lo;
    bit          p_div0;

    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output bit dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin
                if (b == 0) dz = 1'b1;
                else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
            end
            3'd3: begin
                if (b == 0) dz = 1'b1;
                else begin hi = a % b; lo = a / b; end
            end
            default: ;
        endcase
    endtask

    always @(posedge Clk) begin
        cyc++;
        if (Clr !== 1'b1) begin
            m_hi    = '0;
            m_lo    = '0;
            done_at = -1;
        end else if (done_at >= 0) begin
            if (bus.Start === 1'b1)
                $display("note: protocol violation at cycle %0d: Start op %0d while Busy",
                         cyc, bus.Op);
            if (cyc == done_at) begin
                if (!p_div0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
                done_at = -1;
            end
        end else if (bus.Start === 1'b1) begin
            if (bus.Op < 3'd4) begin
                ref_op(bus.Op, bus.A, bus.B, p_hi, p_lo, p_div0);
                done_at = cyc + ((bus.Op >= 3'd2) ? DIV_N : MULT_N);
            end else if (bus.Op == 3'd4) begin
                m_hi = bus.A;
            end else if (bus.Op == 3'd5) begin
                m_lo = bus.A;
            end
        end
    end

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge Clk) begin
        if (chk_en) begin
            n_cmp++;
            if (bus.Busy !== (done_at >= 0) || bus.HI !== m_hi || bus.LO !== m_lo) begin
                n_bad++;
                $display("FAIL model_cmp cyc=%0d got busy=%b hi=%h lo=%h want busy=%b hi=%h lo=%h",
                         cyc, bus.Busy, bus.HI, bus.LO, (done_at >= 0), m_hi, m_lo);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.Start = 1'b0;
    endtask

    // Counts Busy cycles from the current one, bounded.
    task automatic busy_len(output int n);
        n = 0;
        while (bus.Busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        busy_len(n);
        if (n >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout got=busy want=idle", name);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [2:0]  op;
        logic [31:0] a, b;

        bus.Start = 1'b0;
        bus.Op    = '0;
        bus.A     = '0;
        bus.B     = '0;
        Clr       = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        check("reset_busy", {31'd0, bus.Busy}, 32'd0);
        check("reset_hi", bus.HI, 32'd0);
        check("reset_lo", bus.LO, 32'd0);
        Clr = 1'b1;
        tick();

        // MULT -2 * 3
        start_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        busy_len(n);
        check("mult_busy_len", n, 32'd5);
        check("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check("mult_lo", bus.LO, 32'hFFFF_FFFA);

        // MULTU with operand change during RUN
        start_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        bus.A = 32'd0;
        busy_len(n);
        check("multu_busy_len", n, 32'd5);
        check("multu_hi", bus.HI, 32'h0000_0001);
        check("multu_lo", bus.LO, 32'hFFFF_FFFE);

        // DIV -7 / 2
        start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        busy_len(n);
        check("div_busy_len", n, 32'd10);
        check("div_lo", bus.LO, 32'hFFFF_FFFD);
        check("div_hi", bus.HI, 32'hFFFF_FFFF);

        // DIVU by zero leaves HI/LO alone
        start_op(3'd4, 32'h11, 32'd0);
        start_op(3'd5, 32'h22, 32'd0);
        check("mthi_pre", bus.HI, 32'h11);
        check("mtlo_pre", bus.LO, 32'h22);
        start_op(3'd3, 32'd7, 32'd0);
        busy_len(n);
        check("divu0_busy_len", n, 32'd10);
        check("divu0_hi", bus.HI, 32'h11);
        check("divu0_lo", bus.LO, 32'h22);

        // DIV overflow
        start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_len(n);
        check("divovf_lo", bus.LO, 32'h8000_0000);
        check("divovf_hi", bus.HI, 32'h0);

        // MTHI is single-cycle
        start_op(3'd4, 32'hDEAD_BEEF, 32'd0);
        check("mthi_busy", {31'd0, bus.Busy}, 32'd0);
        check("mthi_hi", bus.HI, 32'hDEAD_BEEF);

        // Reset on the 4th Busy cycle of a DIV
        start_op(3'd2, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        Clr = 1'b0;
        tick();
        Clr = 1'b1;
        check("abort_busy", {31'd0, bus.Busy}, 32'd0);
        check("abort_hi", bus.HI, 32'd0);
        check("abort_lo", bus.LO, 32'd0);
        repeat (12) tick();
        check("abort_late_hi", bus.HI, 32'd0);
        check("abort_late_lo", bus.LO, 32'd0);

        // MTLO while Busy is ignored; DIV still commits on schedule
        start_op(3'd2, 32'd100, 32'd7);
        start_op(3'd5, 32'h55, 32'd0);
        busy_len(n);
        check("ovl_busy_len", 1 + n, 32'd10);
        check("ovl_lo", bus.LO, 32'd14);
        check("ovl_hi", bus.HI, 32'd2);

        // Random traffic, checked by the model every cycle
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 99) < 3) begin
                Clr = 1'b0;
                tick();
                Clr = 1'b1;
                continue;
            end
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                3: b = -32'($urandom_range(1, 9));
                default: ;
            endcase
            start_op(op, a, b);
            if (op < 3'd4 && $urandom_range(0, 7) == 0) begin
                tick();
                start_op(3'($urandom_range(0, 7)), $urandom, $urandom);
            end
            wait_idle("rand");
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the Execute stage, beside the ALU.
- Takes rs/rt operands from the E-stage pipeline register and owns the architectural HI/LO registers.
- Models fixed multi-cycle latency through a Busy flag that the hazard logic uses to stall D and bubble E.
- HI/LO outputs feed the mfhi/mflo result mux ahead of the M-stage register.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for MULT/MULTU (≥1).
- DIV_CYCLES, 10, number of Busy cycles for DIV/DIVU (≥1).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Clr  input  1  reset; one clock; reset is synchronous and active-low (Clr=0 sampled at a rising edge resets).
- Start  input  1  one-cycle request to run Op; sampled at the rising edge.
- Op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are reserved (no-op).
- A  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- B  input  32  rt operand (divisor / multiplier).
- Busy  output  1  high while a multiply or divide is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset:
  - Busy=0, HI=0, LO=0, internal counter=0, pending result cleared.
  - Reset has priority over everything, including mid-operation: the in-flight result is discarded and HI/LO become 0.
- States: IDLE, RUN.
- IDLE with Start=1, Op in {0..3}:
  - At the edge, compute the 64-bit result from A/B and hold it in pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES and go to RUN.
  - Busy=1 from the cycle after Start.
- IDLE with Start=1, Op=MTHI: HI<=A at that edge. Op=MTLO: LO<=A at that edge. Busy stays 0; readable the next cycle.
- IDLE with Start=1 and Op in {6,7}: no effect.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter goes 1->0: HI/LO <= pending, Busy->0, return to IDLE.
  - Total: Busy high for exactly N cycles, and the new HI/LO are visible in the first cycle Busy=0.
- Start while in RUN (any Op) is ignored; HI/LO and the counter are unaffected. The hazard unit must never issue this; the bench flags it as a protocol error.
- HI/LO outputs are register values. Reads during RUN return the old values; the hazard unit stalls mfhi/mflo while Busy=1 or Start=1.
- MULT: signed 32x32 -> 64; HI=product[63:32], LO=product[31:0].
- MULTU: same, unsigned.
- DIV: signed division, quotient truncates toward zero. LO=quotient, HI=remainder; the remainder takes the sign of the dividend.
- DIVU: unsigned division; LO=quotient, HI=remainder.
- Divide by zero (B=0, DIV or DIVU): the op still runs DIV_CYCLES with Busy; HI/LO stay unchanged at completion.
- DIV overflow (A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0.
- Operands are captured at Start; changes on A/B during RUN have no effect.

Decomposition:
- Shared package md_pkg holds:
  - the Op encodings (MD_MULT..MD_MTLO);
  - the IDLE/RUN state constants;
  - default cycle counts.
- One combinational sub-module, md_calc (A, B, Op -> 64-bit result plus a div0 flag), isolates the signed/unsigned arithmetic and corner cases. md_unit keeps the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset, then Start MULT with A=0xFFFFFFFE (-2), B=3 -> Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with A=0xFFFFFFFF, B=2 -> after 5 Busy cycles HI=0x00000001, LO=0xFFFFFFFE. Changing A to 0 during RUN has no effect.
- DIV with A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU with A=7, B=0, starting from HI=0x11, LO=0x22 -> Busy for 10 cycles, then HI=0x11, LO=0x22.
- DIV overflow A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0xDEADBEEF -> HI=0xDEADBEEF next cycle, Busy never rises.
- Start DIV, drive Clr=0 on the 4th Busy cycle -> next cycle Busy=0, HI=LO=0, and no later update occurs.
- Start MTLO while Busy -> LO unchanged; the pending DIV result still commits on schedule.
